// File: rtl/apu_mbox_pkg.sv
// Shared definitions for the APU-to-host mailbox: register offsets, STAT
// bit positions and a helper that assembles a STAT word.
package apu_mbox_pkg;

    // Byte offsets of the registers within each port's window.
    localparam logic [15:0] REG_OFF_DATA   = 16'h0000;
    localparam logic [15:0] REG_OFF_STAT   = 16'h0004;
    localparam logic [15:0] REG_OFF_IRQ_EN = 16'h0008;

    // STAT bit positions.
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_LEVEL_LSB = 4;
    localparam int STAT_LEVEL_MSB = 8;
    localparam int STAT_OVF_BIT   = 16;
    localparam int STAT_UNF_BIT   = 17;
    localparam int STAT_LEVEL_W   = STAT_LEVEL_MSB - STAT_LEVEL_LSB + 1;

    // Word index decoded from haddr[3:2]; upper address bits alias.
    typedef enum logic [1:0] {
        REG_DATA   = REG_OFF_DATA[3:2],
        REG_STAT   = REG_OFF_STAT[3:2],
        REG_IRQ_EN = REG_OFF_IRQ_EN[3:2],
        REG_RSVD   = 2'd3
    } reg_idx_e;

    // Assemble a STAT register image; unused bits read as zero.
    function automatic logic [31:0] stat_word(
        input logic                    full,
        input logic                    empty,
        input logic [STAT_LEVEL_W-1:0] level,
        input logic                    ovf,
        input logic                    unf
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        w[STAT_FULL_BIT]                  = full;
        w[STAT_EMPTY_BIT]                 = empty;
        w[STAT_LEVEL_MSB:STAT_LEVEL_LSB]  = level;
        w[STAT_OVF_BIT]                   = ovf;
        w[STAT_UNF_BIT]                   = unf;
        return w;
    endfunction

endpackage

// File: rtl/apu_mbox_if.sv
// AHB-Lite slave port bundle used by both sides of the mailbox.
interface apu_mbox_if;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic [31:0] hwdata;
    logic        hready_resp;
    logic [31:0] hrdata;
    logic        hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hready, hwdata,
        input  hready_resp, hrdata, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hready, hwdata,
        output hready_resp, hrdata, hresp
    );
endinterface

// File: rtl/apu_mbox_fifo.sv
// Word FIFO for the mailbox. A push while full is accepted only when a pop
// happens in the same cycle; a pop while empty is refused and flagged, while
// a simultaneous push still lands.
module apu_mbox_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_req,
    input  logic                     pop_req,
    input  logic [31:0]              wdata,
    output logic [31:0]              head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_evt,
    output logic                     unf_evt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1'b1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};

    logic [31:0]   mem_r [DEPTH];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [LW-1:0] level_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Accept/refuse decisions; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        full      = (level_r == LVL_FULL);
        empty     = (level_r == LVL_ZERO);
        pop_ok_s  = pop_req & ~empty;
        push_ok_s = push_req & (~full | pop_req);
        ovf_evt   = push_req & ~push_ok_s;
        unf_evt   = pop_req & empty;
        head      = mem_r[rptr_r];
        level     = level_r;
    end

    // Storage write; contents need no reset since empty slots are never read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            level_r <= LVL_ZERO;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/apu_mbox.sv
// APU-to-host mailbox: APU pushes words through its AHB-Lite port, the host
// pops them through its own. Level interrupts announce "message waiting"
// to the host and "mailbox drained" to the APU.
module apu_mbox
    import apu_mbox_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    apu_mbox_if.slave  apu_ahbls,
    apu_mbox_if.slave  host_ahbls,
    output logic       host_irq,
    output logic       apu_irq
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic        apu_sel_r, apu_wr_r;
    reg_idx_e    apu_idx_r;
    logic        host_sel_r, host_wr_r;
    reg_idx_e    host_idx_r;

    logic        ovf_r, unf_r;
    logic        apu_irq_en_r, host_irq_en_r;
    logic        host_irq_r, apu_irq_r;

    logic        push_s, pop_s;
    logic        apu_stat_wr_s, apu_en_wr_s;
    logic        host_stat_wr_s, host_en_wr_s;
    logic [31:0] head_s;
    logic        full_s, empty_s, ovf_evt_s, unf_evt_s;
    logic [LW-1:0]           level_s;
    logic [STAT_LEVEL_W-1:0] level_ext_s;
    logic [31:0] apu_rdata_s, host_rdata_s;
    logic        unused_s;

    // APU address-phase capture into the data phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apu_sel_r <= 1'b0;
            apu_wr_r  <= 1'b0;
            apu_idx_r <= REG_DATA;
        end else if (apu_ahbls.hready) begin
            apu_sel_r <= apu_ahbls.htrans[1];
            apu_wr_r  <= apu_ahbls.hwrite;
            apu_idx_r <= reg_idx_e'(apu_ahbls.haddr[3:2]);
        end
    end

    // Host address-phase capture into the data phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_sel_r <= 1'b0;
            host_wr_r  <= 1'b0;
            host_idx_r <= REG_DATA;
        end else if (host_ahbls.hready) begin
            host_sel_r <= host_ahbls.htrans[1];
            host_wr_r  <= host_ahbls.hwrite;
            host_idx_r <= reg_idx_e'(host_ahbls.haddr[3:2]);
        end
    end

    // Data-phase command decode for both ports.
    always_comb begin
        push_s         = apu_sel_r  &  apu_wr_r  & (apu_idx_r  == REG_DATA);
        apu_stat_wr_s  = apu_sel_r  &  apu_wr_r  & (apu_idx_r  == REG_STAT);
        apu_en_wr_s    = apu_sel_r  &  apu_wr_r  & (apu_idx_r  == REG_IRQ_EN);
        pop_s          = host_sel_r & ~host_wr_r & (host_idx_r == REG_DATA);
        host_stat_wr_s = host_sel_r &  host_wr_r & (host_idx_r == REG_STAT);
        host_en_wr_s   = host_sel_r &  host_wr_r & (host_idx_r == REG_IRQ_EN);
    end

    apu_mbox_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_req (push_s),
        .pop_req  (pop_s),
        .wdata    (apu_ahbls.hwdata),
        .head     (head_s),
        .full     (full_s),
        .empty    (empty_s),
        .level    (level_s),
        .ovf_evt  (ovf_evt_s),
        .unf_evt  (unf_evt_s)
    );

    // Sticky error flags; a new event beats a same-cycle W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (ovf_evt_s) begin
                ovf_r <= 1'b1;
            end else if (apu_stat_wr_s && apu_ahbls.hwdata[STAT_OVF_BIT]) begin
                ovf_r <= 1'b0;
            end
            if (unf_evt_s) begin
                unf_r <= 1'b1;
            end else if (host_stat_wr_s && host_ahbls.hwdata[STAT_UNF_BIT]) begin
                unf_r <= 1'b0;
            end
        end
    end

    // Interrupt enables, written through each side's IRQ_EN register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apu_irq_en_r  <= 1'b0;
            host_irq_en_r <= 1'b0;
        end else begin
            if (apu_en_wr_s) begin
                apu_irq_en_r <= apu_ahbls.hwdata[0];
            end
            if (host_en_wr_s) begin
                host_irq_en_r <= host_ahbls.hwdata[0];
            end
        end
    end

    // Registered level interrupts, one cycle behind the state they reflect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_irq_r <= 1'b0;
            apu_irq_r  <= 1'b0;
        end else begin
            host_irq_r <= host_irq_en_r & ~empty_s;
            apu_irq_r  <= apu_irq_en_r & empty_s;
        end
    end

    // Zero-extend the FIFO level into the STAT level field.
    always_comb begin
        level_ext_s        = {STAT_LEVEL_W{1'b0}};
        level_ext_s[LW-1:0] = level_s;
    end

    // APU read mux, driven only during a read data phase.
    always_comb begin
        apu_rdata_s = 32'h0000_0000;
        if (apu_sel_r && !apu_wr_r) begin
            case (apu_idx_r)
                REG_STAT:   apu_rdata_s = stat_word(full_s, empty_s, level_ext_s, ovf_r, 1'b0);
                REG_IRQ_EN: apu_rdata_s = {31'h0000_0000, apu_irq_en_r};
                default:    apu_rdata_s = 32'h0000_0000;
            endcase
        end else begin
            apu_rdata_s = 32'h0000_0000;
        end
    end

    // Host read mux; an RX read of an empty mailbox returns zero.
    always_comb begin
        host_rdata_s = 32'h0000_0000;
        if (host_sel_r && !host_wr_r) begin
            case (host_idx_r)
                REG_DATA:   host_rdata_s = empty_s ? 32'h0000_0000 : head_s;
                REG_STAT:   host_rdata_s = stat_word(full_s, empty_s, level_ext_s, 1'b0, unf_r);
                REG_IRQ_EN: host_rdata_s = {31'h0000_0000, host_irq_en_r};
                default:    host_rdata_s = 32'h0000_0000;
            endcase
        end else begin
            host_rdata_s = 32'h0000_0000;
        end
    end

    assign apu_ahbls.hrdata       = apu_rdata_s;
    assign apu_ahbls.hready_resp  = 1'b1;
    assign apu_ahbls.hresp        = 1'b0;
    assign host_ahbls.hrdata      = host_rdata_s;
    assign host_ahbls.hready_resp = 1'b1;
    assign host_ahbls.hresp       = 1'b0;
    assign host_irq               = host_irq_r;
    assign apu_irq                = apu_irq_r;

    // Request fields the word-only, 4-register decode never looks at.
    assign unused_s = ^{apu_ahbls.hsize, apu_ahbls.haddr[15:4], apu_ahbls.haddr[1:0],
                        apu_ahbls.htrans[0], host_ahbls.hsize, host_ahbls.haddr[15:4],
                        host_ahbls.haddr[1:0], host_ahbls.htrans[0], host_ahbls.hwdata};

endmodule

// File: tb/tb_apu_mbox.sv
// Self-checking bench for apu_mbox: directed scenarios with literal
// expectations, then randomized traffic on both ports against a queue model.
module tb_apu_mbox;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic host_irq, apu_irq;

    always #5 clk = ~clk;

    apu_mbox_if apu_bus ();
    apu_mbox_if host_bus ();

    apu_mbox #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .apu_ahbls  (apu_bus),
        .host_ahbls (host_bus),
        .host_irq   (host_irq),
        .apu_irq    (apu_irq)
    );

    typedef struct {
        logic        v;
        logic        w;
        logic [1:0]  idx;
        logic [15:0] addr;
        logic [2:0]  hsize;
        logic [31:0] wdata;
        logic        lit_en;
        logic [31:0] lit;
    } op_t;

    // Behavioural model state.
    logic [31:0] q[$];
    bit  m_ovf, m_unf, m_apu_en, m_host_en;
    bit  e_host_irq, e_apu_irq;
    op_t aph_a, aph_h, dph_a, dph_h;
    int  checks = 0;
    int  passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic op_t idle_op();
        op_t o;
        o.v = 1'b0; o.w = 1'($urandom); o.idx = 2'($urandom);
        o.addr = 16'($urandom); o.hsize = 3'd2; o.wdata = $urandom;
        o.lit_en = 1'b0; o.lit = 32'h0;
        return o;
    endfunction

    function automatic op_t mk(input logic w, input logic [1:0] idx, input logic [31:0] wdata,
                               input logic lit_en, input logic [31:0] lit);
        op_t o;
        o.v = 1'b1; o.w = w; o.idx = idx;
        o.addr = 16'($urandom); o.addr[3:2] = idx;
        o.hsize = 3'($urandom_range(0, 2));
        o.wdata = w ? wdata : $urandom;
        o.lit_en = lit_en; o.lit = lit;
        return o;
    endfunction

    function automatic op_t wr(input logic [1:0] idx, input logic [31:0] d);
        return mk(1'b1, idx, d, 1'b0, 32'h0);
    endfunction
    function automatic op_t rd(input logic [1:0] idx);
        return mk(1'b0, idx, 32'h0, 1'b0, 32'h0);
    endfunction
    function automatic op_t rdl(input logic [1:0] idx, input logic [31:0] lit);
        return mk(1'b0, idx, 32'h0, 1'b1, lit);
    endfunction

    // STAT as the spec lays it out, computed from the queue.
    function automatic logic [31:0] stat_exp(input bit host_side);
        logic [31:0] s;
        s = 32'h0;
        s[0]   = (q.size() == DEPTH);
        s[1]   = (q.size() == 0);
        s[8:4] = 5'(q.size());
        if (host_side) s[17] = m_unf;
        else           s[16] = m_ovf;
        return s;
    endfunction

    function automatic logic [31:0] apu_rd_exp(input logic [1:0] idx);
        case (idx)
            2'd1:    return stat_exp(1'b0);
            2'd2:    return {31'h0, m_apu_en};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] host_rd_exp(input logic [1:0] idx);
        case (idx)
            2'd0:    return (q.size() != 0) ? q[0] : 32'h0;
            2'd1:    return stat_exp(1'b1);
            2'd2:    return {31'h0, m_host_en};
            default: return 32'h0;
        endcase
    endfunction

    // Apply the effect of the data phases that end at this clock edge.
    task automatic model_edge();
        bit push, pop;
        e_host_irq = m_host_en && (q.size() != 0);
        e_apu_irq  = m_apu_en && (q.size() == 0);
        push = dph_a.v && dph_a.w && dph_a.idx == 2'd0;
        pop  = dph_h.v && !dph_h.w && dph_h.idx == 2'd0;
        if (dph_a.v && dph_a.w && dph_a.idx == 2'd1 && dph_a.wdata[16]) m_ovf = 1'b0;
        if (dph_h.v && dph_h.w && dph_h.idx == 2'd1 && dph_h.wdata[17]) m_unf = 1'b0;
        if (dph_a.v && dph_a.w && dph_a.idx == 2'd2) m_apu_en = dph_a.wdata[0];
        if (dph_h.v && dph_h.w && dph_h.idx == 2'd2) m_host_en = dph_h.wdata[0];
        if (pop) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_unf = 1'b1;
        end
        if (push) begin
            if (q.size() < DEPTH) q.push_back(dph_a.wdata);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic drive();
        apu_bus.htrans  = aph_a.v ? {1'b1, 1'($urandom)} : 2'b00;
        apu_bus.haddr   = aph_a.addr;
        apu_bus.hwrite  = aph_a.w;
        apu_bus.hsize   = aph_a.hsize;
        apu_bus.hready  = 1'b1;
        apu_bus.hwdata  = dph_a.wdata;
        host_bus.htrans = aph_h.v ? {1'b1, 1'($urandom)} : 2'b00;
        host_bus.haddr  = aph_h.addr;
        host_bus.hwrite = aph_h.w;
        host_bus.hsize  = aph_h.hsize;
        host_bus.hready = 1'b1;
        host_bus.hwdata = dph_h.wdata;
    endtask

    // One bus cycle: commit finished data phases, start new address phases.
    task automatic step(input op_t a, input op_t h);
        @(posedge clk);
        model_edge();
        dph_a = aph_a; dph_h = aph_h;
        aph_a = a;     aph_h = h;
        #1;
        drive();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(idle_op(), idle_op());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        m_ovf = 0; m_unf = 0; m_apu_en = 0; m_host_en = 0;
        e_host_irq = 0; e_apu_irq = 0;
        aph_a = idle_op(); aph_h = idle_op(); dph_a = idle_op(); dph_h = idle_op();
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        check("apu_hready",  {31'h0, apu_bus.hready_resp},  32'd1);
        check("apu_hresp",   {31'h0, apu_bus.hresp},        32'd0);
        check("host_hready", {31'h0, host_bus.hready_resp}, 32'd1);
        check("host_hresp",  {31'h0, host_bus.hresp},       32'd0);
        check("host_irq",    {31'h0, host_irq}, {31'h0, e_host_irq});
        check("apu_irq",     {31'h0, apu_irq},  {31'h0, e_apu_irq});
        if (!rst_n) begin
            check("apu_hrdata_rst",  apu_bus.hrdata,  32'h0);
            check("host_hrdata_rst", host_bus.hrdata, 32'h0);
        end else begin
            if (dph_a.v && !dph_a.w) begin
                check("apu_hrdata", apu_bus.hrdata, apu_rd_exp(dph_a.idx));
                if (dph_a.lit_en) check("apu_hrdata_lit", apu_bus.hrdata, dph_a.lit);
            end
            if (dph_h.v && !dph_h.w) begin
                check("host_hrdata", host_bus.hrdata, host_rd_exp(dph_h.idx));
                if (dph_h.lit_en) check("host_hrdata_lit", host_bus.hrdata, dph_h.lit);
            end
        end
    end

    function automatic op_t rand_apu();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2)      return idle_op();
        else if (r < 6) return wr(2'd0, $urandom);
        else if (r < 7) return rd(2'd1);
        else if (r < 8) return wr(2'd1, $urandom);
        else if (r < 9) return ($urandom_range(0, 1) != 0) ? wr(2'd2, $urandom) : rd(2'd2);
        else            return ($urandom_range(0, 1) != 0) ? rd(2'($urandom)) : wr(2'd3, $urandom);
    endfunction

    function automatic op_t rand_host();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2)      return idle_op();
        else if (r < 6) return rd(2'd0);
        else if (r < 7) return rd(2'd1);
        else if (r < 8) return wr(2'd1, $urandom);
        else if (r < 9) return ($urandom_range(0, 1) != 0) ? wr(2'd2, $urandom) : rd(2'd2);
        else            return ($urandom_range(0, 1) != 0) ? wr(2'd0, $urandom) : rd(2'd3);
    endfunction

    initial begin
        do_reset();

        // Reset state of both STAT registers.
        step(rdl(2'd1, 32'h0000_0002), rdl(2'd1, 32'h0000_0002));
        idle_steps(2);

        // Single message with host interrupt.
        step(idle_op(), wr(2'd2, 32'h1));
        step(wr(2'd0, 32'hA5A5_0001), idle_op());
        idle_steps(3);
        @(negedge clk); check("host_irq_rise", {31'h0, host_irq}, 32'd1);
        step(idle_op(), rdl(2'd0, 32'hA5A5_0001));
        step(idle_op(), rdl(2'd1, 32'h0000_0002));
        idle_steps(2);
        @(negedge clk); check("host_irq_fall", {31'h0, host_irq}, 32'd0);

        // Overflow then underflow, then W1C both flags.
        for (int i = 1; i <= 5; i++) step(wr(2'd0, 32'(i)), idle_op());
        idle_steps(2);
        step(rdl(2'd1, 32'h0001_0041), idle_op());
        for (int i = 1; i <= 4; i++) step(idle_op(), rdl(2'd0, 32'(i)));
        step(idle_op(), rdl(2'd0, 32'h0));
        step(idle_op(), idle_op());
        step(idle_op(), rdl(2'd1, 32'h0002_0002));
        step(wr(2'd1, 32'h0003_0000), wr(2'd1, 32'h0003_0000));
        step(rdl(2'd1, 32'h0000_0002), rdl(2'd1, 32'h0000_0002));

        // Push and pop together while full.
        for (int i = 0; i < 4; i++) step(wr(2'd0, 32'h11 + 32'(i)), idle_op());
        step(wr(2'd0, 32'h15), rdl(2'd0, 32'h11));
        step(rdl(2'd1, 32'h0000_0041), idle_op());
        for (int i = 0; i < 4; i++) step(idle_op(), rdl(2'd0, 32'h12 + 32'(i)));

        // Push and pop together while empty.
        step(wr(2'd0, 32'h77), rdl(2'd0, 32'h0));
        step(idle_op(), rdl(2'd1, 32'h0002_0010));
        step(idle_op(), rdl(2'd0, 32'h77));
        step(idle_op(), wr(2'd1, 32'h0002_0000));
        step(idle_op(), rdl(2'd1, 32'h0000_0002));

        // APU drained interrupt.
        step(wr(2'd2, 32'h1), idle_op());
        step(wr(2'd0, 32'h21), idle_op());
        step(wr(2'd0, 32'h22), idle_op());
        idle_steps(3);
        @(negedge clk); check("apu_irq_low", {31'h0, apu_irq}, 32'd0);
        step(idle_op(), rdl(2'd0, 32'h21));
        step(idle_op(), rdl(2'd0, 32'h22));
        idle_steps(3);
        @(negedge clk); check("apu_irq_high", {31'h0, apu_irq}, 32'd1);

        // Reset in the middle of a burst.
        step(wr(2'd0, 32'h31), idle_op());
        step(wr(2'd0, 32'h32), rd(2'd0));
        step(wr(2'd0, 32'h33), idle_op());
        do_reset();
        step(rdl(2'd1, 32'h0000_0002), rdl(2'd1, 32'h0000_0002));
        step(rdl(2'd2, 32'h0), rdl(2'd2, 32'h0));
        idle_steps(2);
        @(negedge clk);
        check("host_irq_post_rst", {31'h0, host_irq}, 32'd0);
        check("apu_irq_post_rst",  {31'h0, apu_irq},  32'd0);

        // Randomized traffic on both ports.
        for (int i = 0; i < 600; i++) step(rand_apu(), rand_host());
        idle_steps(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
